// File: rtl/gpio_port_af.sv
// GPIO bank with an Avalon-MM register file, per-pin alternate-function mux, input synchroniser,
// edge capture with write-one-to-clear, and a maskable level interrupt.
module gpio_port_af #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = 32'h0,
    parameter logic [31:0] DIR_RESET   = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    input  logic [WIDTH-1:0] af_out,
    input  logic [WIDTH-1:0] af_oe
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_SET      = 3'd2;
    localparam logic [2:0] ADDR_CLR      = 3'd3;
    localparam logic [2:0] ADDR_AF       = 3'd4;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd6;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd7;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] af_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] sel_q;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev_q;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;

    logic [WIDTH-1:0] wdata;
    logic             wr_data;
    logic             wr_dir;
    logic             wr_set;
    logic             wr_clr;
    logic             wr_af;
    logic             wr_mask;
    logic             wr_cap;
    logic             wr_sel;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] cap_next;
    logic [WIDTH-1:0] mask_next;
    logic [31:0]      rd_mux;

    // Write strobes per register
    assign wdata   = avs_writedata[WIDTH-1:0];
    assign wr_data = avs_write && (avs_address == ADDR_DATA);
    assign wr_dir  = avs_write && (avs_address == ADDR_DIR);
    assign wr_set  = avs_write && (avs_address == ADDR_SET);
    assign wr_clr  = avs_write && (avs_address == ADDR_CLR);
    assign wr_af   = avs_write && (avs_address == ADDR_AF);
    assign wr_mask = avs_write && (avs_address == ADDR_IRQ_MASK);
    assign wr_cap  = avs_write && (avs_address == ADDR_EDGE_CAP);
    assign wr_sel  = avs_write && (avs_address == ADDR_EDGE_SEL);

    // Pin ownership: alternate function overrides both value and enable
    assign gpio_out = (af_q & af_out) | (~af_q & out_q);
    assign gpio_oe  = (af_q & af_oe)  | (~af_q & dir_q);

    // Control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q  <= OUT_RESET[WIDTH-1:0];
            dir_q  <= DIR_RESET[WIDTH-1:0];
            af_q   <= {WIDTH{1'b0}};
            mask_q <= {WIDTH{1'b0}};
            sel_q  <= {WIDTH{1'b0}};
        end else begin
            if (wr_data) begin
                out_q <= wdata;
            end else if (wr_set) begin
                out_q <= out_q | wdata;
            end else if (wr_clr) begin
                out_q <= out_q & ~wdata;
            end
            if (wr_dir) begin
                dir_q <= wdata;
            end
            if (wr_af) begin
                af_q <= wdata;
            end
            if (wr_mask) begin
                mask_q <= wdata;
            end
            if (wr_sel) begin
                sel_q <= wdata;
            end
        end
    end

    // Input synchroniser, one-cycle history and post-reset arming counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prev_q  <= {WIDTH{1'b0}};
            arm_cnt <= {ARM_W{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q <= sync;
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    assign sync  = sync_q[SYNC_STAGES-1];
    assign armed = (arm_cnt == ARM_W'(ARM_MAX));

    // Edge events; a new event wins over a simultaneous write-one-to-clear
    assign rise      = sync & ~prev_q;
    assign fall      = ~sync & prev_q;
    assign ev        = armed ? ((sel_q & rise) | (~sel_q & fall)) : {WIDTH{1'b0}};
    assign w1c       = wr_cap ? wdata : {WIDTH{1'b0}};
    assign cap_next  = (cap_q & ~w1c) | ev;
    assign mask_next = wr_mask ? wdata : mask_q;

    // Capture register and interrupt track the post-edge capture and mask state together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= {WIDTH{1'b0}};
            irq   <= 1'b0;
        end else begin
            cap_q <= cap_next;
            irq   <= |(cap_next & mask_next);
        end
    end

    // Read mux, narrow registers zero-extended
    always_comb begin
        rd_mux = {DATA_W{1'b0}};
        case (avs_address)
            ADDR_DATA:     rd_mux = DATA_W'(sync);
            ADDR_DIR:      rd_mux = DATA_W'(dir_q);
            ADDR_SET:      rd_mux = DATA_W'(out_q);
            ADDR_CLR:      rd_mux = DATA_W'(out_q);
            ADDR_AF:       rd_mux = DATA_W'(af_q);
            ADDR_IRQ_MASK: rd_mux = DATA_W'(mask_q);
            ADDR_EDGE_CAP: rd_mux = DATA_W'(cap_q);
            ADDR_EDGE_SEL: rd_mux = DATA_W'(sel_q);
            default:       rd_mux = {DATA_W{1'b0}};
        endcase
    end

    // Fixed one-cycle read latency; data holds between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= {DATA_W{1'b0}};
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule
